// File: rtl/conv_mem_responder.sv
// conv_mem_responder: image and layer memories behind the conv engine, plus the
// ready/busy start handshake and the host-side image load and layer readback paths.
module conv_mem_responder #(
    parameter int DW       = 20,
    parameter int AW       = 12,
    parameter int L1_DEPTH = 1024,
    parameter int TIMEOUT  = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          crd,
    input  logic          cwr,
    input  logic [2:0]    csel,
    input  logic [AW-1:0] caddr_rd,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    output logic [DW-1:0] cdata_rd,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          start,
    output logic          done,
    output logic          err,
    input  logic [2:0]    rb_sel,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data
);
    // state | meaning
    // IDLE  | no run; host may load the image
    // ARM   | ready raised, waiting up to TIMEOUT cycles for busy
    // RUN   | engine busy
    // DONE  | run complete; host reads back, next start re-arms

    localparam int MEM_DEPTH = 1 << AW;
    localparam int L1_AW     = $clog2(L1_DEPTH);
    localparam int TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [2:0] SEL_L0 = 3'b001;
    localparam logic [2:0] SEL_L1 = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          err_q, err_d;
    logic [DW-1:0] rd_hold_q;
    logic          timeout_err;

    logic [DW-1:0] img_mem [MEM_DEPTH];
    logic [DW-1:0] l0_mem  [MEM_DEPTH];
    logic [DW-1:0] l1_mem  [L1_DEPTH];

    logic          sel_l0, sel_l1, sel_ok;
    logic          host_phase;
    logic          img_we, l0_we, l1_we, l1_addr_ok;
    logic          ld_err, wr_err, rd_err;
    logic [DW-1:0] rd_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tmr_q     <= '0;
            err_q     <= 1'b0;
            rd_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            err_q     <= err_d;
            rd_hold_q <= cdata_rd;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    tmr_d   = TW'(TIMEOUT - 1);
                end
            end
            ARM: begin
                if (busy) begin
                    state_d = RUN;
                end else if (tmr_q == '0) begin
                    state_d     = IDLE;
                    timeout_err = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            RUN: begin
                if (!busy) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = ARM;
                    tmr_d   = TW'(TIMEOUT - 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready = (state_q == ARM);
    assign done  = (state_q == DONE);
    assign err   = err_q;

    assign sel_l0     = (csel == SEL_L0);
    assign sel_l1     = (csel == SEL_L1);
    assign sel_ok     = sel_l0 | sel_l1;
    assign host_phase = (state_q == IDLE) | (state_q == DONE);
    assign l1_addr_ok = (caddr_wr < AW'(L1_DEPTH));

    assign img_we = ld_en & host_phase;
    assign l0_we  = cwr & sel_l0;
    assign l1_we  = cwr & sel_l1 & l1_addr_ok;
    assign ld_err = ld_en & ~host_phase;
    assign wr_err = cwr & (~sel_ok | (sel_l1 & ~l1_addr_ok));
    assign rd_err = crd & ~sel_ok;

    // Any error event in the same cycle as a clearing start wins.
    assign err_d = (err_q & ~(start & host_phase)) | timeout_err | ld_err | wr_err | rd_err;

    always_ff @(posedge clk) begin
        if (img_we) img_mem[ld_addr] <= ld_data;
        if (l0_we)  l0_mem[caddr_wr] <= cdata_wr;
        if (l1_we)  l1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
    end

    assign idata = img_mem[iaddr];

    always_comb begin
        rd_word = '0;
        if (sel_l0)      rd_word = l0_mem[caddr_rd];
        else if (sel_l1) rd_word = l1_mem[caddr_rd[L1_AW-1:0]];
    end

    assign cdata_rd = crd ? rd_word : rd_hold_q;

    always_comb begin
        rb_data = '0;
        if (rb_sel == SEL_L0)      rb_data = l0_mem[rb_addr];
        else if (rb_sel == SEL_L1) rb_data = l1_mem[rb_addr[L1_AW-1:0]];
    end

endmodule

// File: tb/tb_conv_mem_responder.sv
// Randomized scoreboard bench for conv_mem_responder: the stimulus side pushes
// expected observations per cycle, a negedge monitor pops and compares them.
module tb_conv_mem_responder;
    localparam int DW  = 20;
    localparam int AW  = 12;
    localparam int L1D = 1024;
    localparam int TMO = 16;

    localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_DONE = 3;
    localparam int K_READY = 0, K_DONE = 1, K_ERR = 2, K_IDATA = 3, K_CDATA = 4, K_RB = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          crd;
    logic          cwr;
    logic [2:0]    csel;
    logic [AW-1:0] caddr_rd;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [DW-1:0] cdata_rd;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          start;
    logic          done;
    logic          err;
    logic [2:0]    rb_sel;
    logic [AW-1:0] rb_addr;
    logic [DW-1:0] rb_data;

    conv_mem_responder dut (
        .clk(clk), .reset_n(reset_n), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata), .crd(crd), .cwr(cwr), .csel(csel),
        .caddr_rd(caddr_rd), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .cdata_rd(cdata_rd), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .done(done), .err(err), .rb_sel(rb_sel), .rb_addr(rb_addr),
        .rb_data(rb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        int            kind;
        logic [DW-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    logic [DW-1:0] img_m [4096];
    logic [DW-1:0] l0_m  [4096];
    logic [DW-1:0] l1_m  [L1D];
    int            ph         = P_IDLE;
    int            arm_cnt    = 0;
    logic          err_m      = 1'b0;
    logic [DW-1:0] hold_m     = '0;
    bit            hold_known = 1'b0;
    bit            full_chk   = 1'b0;

    function automatic string kname(int k);
        case (k)
            K_READY: return "ready";
            K_DONE:  return "done";
            K_ERR:   return "err";
            K_IDATA: return "idata";
            K_CDATA: return "cdata_rd";
            default: return "rb_data";
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t          e;
        logic [DW-1:0] act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_READY: act = DW'(ready);
                K_DONE:  act = DW'(done);
                K_ERR:   act = DW'(err);
                K_IDATA: act = idata;
                K_CDATA: act = cdata_rd;
                default: act = rb_data;
            endcase
            n_total++;
            if (e.cyc != cyc)
                $display("FAIL %s stale expectation cyc=%0d now=%0d", kname(e.kind), e.cyc, cyc);
            else if (act !== e.val)
                $display("FAIL %s cyc=%0d actual=%h required=%h", kname(e.kind), cyc, act, e.val);
            else
                n_pass++;
        end
    end

    task automatic push(int k, logic [DW-1:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    function automatic logic [DW-1:0] bank_rd(logic [2:0] sel, logic [AW-1:0] a);
        if (sel == 3'b001) return l0_m[a];
        if (sel == 3'b011) return l1_m[int'(a) % L1D];
        return '0;
    endfunction

    task automatic quiet();
        start = 1'b0;
        ld_en = 1'b0;
        cwr   = 1'b0;
        crd   = 1'b0;
    endtask

    // One clock cycle: record what the DUT must show now, apply the edge to the model, advance.
    task automatic step();
        logic [DW-1:0] cexp;
        bit            ev;
        if (!reset_n) begin
            ph         = P_IDLE;
            arm_cnt    = 0;
            err_m      = 1'b0;
            hold_known = 1'b0;
        end
        cexp = crd ? bank_rd(csel, caddr_rd) : hold_m;
        push(K_READY, DW'(ph == P_ARM));
        push(K_DONE,  DW'(ph == P_DONE));
        push(K_ERR,   DW'(err_m));
        if (full_chk) begin
            push(K_IDATA, img_m[iaddr]);
            push(K_RB, bank_rd(rb_sel, rb_addr));
            if (crd || hold_known) push(K_CDATA, cexp);
        end
        if (reset_n) begin
            ev = 1'b0;
            if (ld_en) begin
                if (ph == P_IDLE || ph == P_DONE) img_m[ld_addr] = ld_data;
                else ev = 1'b1;
            end
            if (crd && !(csel == 3'b001 || csel == 3'b011)) ev = 1'b1;
            if (cwr) begin
                if (csel == 3'b001) l0_m[caddr_wr] = cdata_wr;
                else if (csel == 3'b011 && int'(caddr_wr) < L1D) l1_m[caddr_wr] = cdata_wr;
                else ev = 1'b1;
            end
            if (crd) begin
                hold_m     = cexp;
                hold_known = 1'b1;
            end
            if (start && (ph == P_IDLE || ph == P_DONE)) err_m = 1'b0;
            case (ph)
                P_IDLE, P_DONE: if (start) begin ph = P_ARM; arm_cnt = 0; end
                P_ARM: begin
                    if (busy) ph = P_RUN;
                    else begin
                        arm_cnt++;
                        if (arm_cnt == TMO) begin ph = P_IDLE; ev = 1'b1; end
                    end
                end
                default: if (!busy) ph = P_DONE;
            endcase
            if (ev) err_m = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_traffic();
        int r;
        quiet();
        iaddr   = AW'($urandom);
        rb_addr = AW'($urandom);
        r = $urandom_range(0, 9);
        rb_sel = (r < 4) ? 3'b001 : (r < 8) ? 3'b011 : 3'($urandom);
        r = $urandom_range(0, 19);
        csel = (r < 9) ? 3'b001 : (r < 18) ? 3'b011 : 3'($urandom);
        crd      = 1'($urandom_range(0, 1));
        caddr_rd = AW'($urandom);
        cwr      = ($urandom_range(0, 2) == 0);
        caddr_wr = (csel == 3'b011 && $urandom_range(0, 7) != 0) ? AW'($urandom_range(0, L1D - 1))
                                                                 : AW'($urandom);
        cdata_wr = DW'($urandom);
        ld_en    = ($urandom_range(0, 9) == 0);
        ld_addr  = AW'($urandom);
        ld_data  = DW'($urandom);
    endtask

    task automatic do_run(int arm_wait, int run_len, bit traffic);
        quiet();
        start = 1'b1;
        busy  = 1'b0;
        step();
        for (int i = 0; i < arm_wait; i++) begin
            if (traffic) rand_traffic(); else quiet();
            busy = 1'b0;
            step();
        end
        for (int i = 0; i < run_len; i++) begin
            if (traffic) rand_traffic(); else quiet();
            busy = 1'b1;
            if (i == 1) start = 1'b1;
            step();
        end
        quiet();
        busy = 1'b0;
        step();
        step();
    endtask

    initial begin
        quiet();
        reset_n = 1'b0; busy = 1'b0; iaddr = '0; csel = '0; caddr_rd = '0; caddr_wr = '0;
        cdata_wr = '0; ld_addr = '0; ld_data = '0; rb_sel = '0; rb_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        step();
        reset_n = 1'b1;
        step();

        for (int k = 0; k < 4096; k++) begin
            quiet(); ld_en = 1'b1; ld_addr = AW'(k); ld_data = DW'(k); step();
        end
        for (int k = 0; k < 4096; k++) begin
            quiet(); cwr = 1'b1; csel = 3'b001; caddr_wr = AW'(k); cdata_wr = DW'($urandom); step();
        end
        for (int k = 0; k < L1D; k++) begin
            quiet(); cwr = 1'b1; csel = 3'b011; caddr_wr = AW'(k); cdata_wr = DW'($urandom); step();
        end
        full_chk = 1'b1;
        quiet();
        step();

        // image readback identity and a first run
        for (int k = 0; k < 8; k++) begin
            quiet(); iaddr = AW'(k * 585); step();
        end
        do_run(2, 4, 1'b0);

        repeat (300) begin rand_traffic(); step(); end
        for (int n = 0; n < 12; n++) do_run($urandom_range(0, 10), $urandom_range(2, 12), 1'b1);

        // far end of L0: write, then readback and layer read
        quiet(); cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd4095; cdata_wr = 20'hABCDE; step();
        quiet(); rb_sel = 3'b001; rb_addr = 12'd4095; crd = 1'b1; csel = 3'b001; caddr_rd = 12'd4095; step();
        quiet(); step();

        // same-cycle read/write: old word now, new word next cycle
        quiet(); cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd10; cdata_wr = 20'd5; step();
        quiet(); crd = 1'b1; cwr = 1'b1; csel = 3'b001; caddr_rd = 12'd10; caddr_wr = 12'd10; cdata_wr = 20'd7; step();
        quiet(); crd = 1'b1; csel = 3'b001; caddr_rd = 12'd10; step();
        quiet(); step();

        // L1 out-of-range write, then invalid-bank write
        do_run(1, 2, 1'b0);
        quiet(); cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd1024; cdata_wr = 20'h12345;
        rb_sel = 3'b011; rb_addr = 12'd0; step();
        quiet(); rb_sel = 3'b011; rb_addr = 12'd0; step();
        do_run(0, 2, 1'b0);
        quiet(); cwr = 1'b1; csel = 3'b010; caddr_wr = 12'd3; cdata_wr = 20'h54321;
        rb_sel = 3'b001; rb_addr = 12'd3; step();
        quiet(); rb_sel = 3'b001; rb_addr = 12'd3; step();
        rb_sel = 3'b010; step();

        // timeout with busy held low, then a start clears err
        quiet(); start = 1'b1; busy = 1'b0; step();
        repeat (20) begin quiet(); busy = 1'b0; step(); end
        do_run(3, 3, 1'b0);

        // reset in the middle of a run
        quiet(); start = 1'b1; step();
        quiet(); busy = 1'b1; step();
        quiet(); ld_en = 1'b1; ld_addr = 12'd7; ld_data = 20'hFFFFF; busy = 1'b1; step();
        quiet(); busy = 1'b1; step();
        quiet(); reset_n = 1'b0; busy = 1'b1; step();
        reset_n = 1'b1; busy = 1'b0;
        quiet(); iaddr = 12'd7; rb_sel = 3'b001; rb_addr = 12'd4095; step();
        repeat (100) begin rand_traffic(); step(); end
        do_run(4, 5, 1'b1);

        quiet();
        repeat (3) step();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
